pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Drives the enable/flush pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Owns the data-memory request/acknowledge handshake for the MEM stage, with a wait-state timeout.
- Resolves load-use, memory-wait, branch-redirect and trap events by fixed priority, and exports a stall-cycle counter.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_mem_handshake.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM encodings, pipeline constants and hazard helpers
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h13;

    // True when an ID source operand is actually read and names register rd.
    function automatic logic reg_hit(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses & (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_mem_handshake.sv
// pipe_mem_handshake: MEM-stage data-memory request/ack FSM with wait-state timeout
//   clk, rst       : clock, synchronous active-high reset
//   mem_access     : MEM stage holds a load or store
//   dmem_ack       : data-memory completion
//   trap           : trap from the MEM-stage instruction, aborts any pending access
//   dmem_req       : data-memory request (combinational)
//   timeout        : last permitted wait cycle passed without ack (combinational)
//   mem_fault      : one-cycle registered pulse following a timeout
module pipe_mem_handshake
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access,
    input  logic dmem_ack,
    input  logic trap,
    output logic dmem_req,
    output logic timeout,
    output logic mem_fault
);

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    mem_state_t state;
    logic [7:0] wait_cnt;

    always_comb begin
        dmem_req = ~rst & ((state == MEM_WAIT) | mem_access);
        timeout  = ~rst & (state == MEM_WAIT) & ~dmem_ack & (wait_cnt == LAST);
    end

    // Any cycle that does not leave a request outstanding returns to IDLE;
    // an outstanding one (first cycle from IDLE or a continued wait) counts up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= timeout;
            if (trap | timeout | ~dmem_req | dmem_ack) begin
                state    <= IDLE;
                wait_cnt <= 8'd0;
            end else begin
                state    <= MEM_WAIT;
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer resolving trap, memory-wait, branch and load-use hazards
//   clk, rst                        : clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs1/rs2  : ID-stage source operands
//   ex_data_re, ex_reg_file_we/rd   : EX-stage load / destination info
//   ex_branch_taken                 : EX redirects the PC
//   mem_data_re/we, dmem_ack        : MEM-stage access and data-memory completion
//   trap                            : trap raised by the MEM-stage instruction
//   dmem_req                        : data-memory request
//   pc_en, *_en, *_flush            : PC and pipeline register controls
//   mem_fault                       : one-cycle pulse after a memory timeout
//   stall_count                     : saturating count of cycles with pc_en=0
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_data_re,
    input  logic                 ex_reg_file_we,
    input  logic [4:0]           ex_reg_file_rd,
    input  logic                 ex_branch_taken,
    input  logic                 mem_data_re,
    input  logic                 mem_data_we,
    input  logic                 dmem_ack,
    input  logic                 trap,
    output logic                 dmem_req,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_en,
    output logic                 mem_wb_flush,
    output logic                 mem_fault,
    output logic [CNT_WIDTH-1:0] stall_count
);

    logic timeout, mem_stall, load_use, flush_all;

    pipe_mem_handshake #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
        .clk        (clk),
        .rst        (rst),
        .mem_access (mem_data_re | mem_data_we),
        .dmem_ack   (dmem_ack),
        .trap       (trap),
        .dmem_req   (dmem_req),
        .timeout    (timeout),
        .mem_fault  (mem_fault)
    );

    // Fixed priority: trap/timeout > memory stall > branch > load-use.
    // A stalled branch or load-use is simply re-evaluated once the stall ends,
    // since EX and ID contents are held.
    always_comb begin
        load_use     = ex_data_re & ex_reg_file_we & (ex_reg_file_rd != 5'd0) &
                       (reg_hit(id_uses_rs1, id_rs1, ex_reg_file_rd) |
                        reg_hit(id_uses_rs2, id_rs2, ex_reg_file_rd));
        flush_all    = ~rst & (trap | timeout);
        mem_stall    = dmem_req & ~dmem_ack & ~timeout;
        pc_en        = ~rst;
        if_id_en     = ~rst;
        id_ex_en     = ~rst;
        ex_mem_en    = ~rst;
        mem_wb_en    = ~rst;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (flush_all) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (~rst & ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (~rst & load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (~pc_en & ~&stall_count)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl against a cycle-level reference model
module tb_pipe_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_reg_file_rd = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_data_re = 0, ex_reg_file_we = 0;
    logic ex_branch_taken = 0, mem_data_re = 0, mem_data_we = 0, dmem_ack = 0, trap = 0;
    logic dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_fault;
    logic [CW-1:0] stall_count;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_data_re(ex_data_re), .ex_reg_file_we(ex_reg_file_we), .ex_reg_file_rd(ex_reg_file_rd),
        .ex_branch_taken(ex_branch_taken), .mem_data_re(mem_data_re), .mem_data_we(mem_data_we),
        .dmem_ack(dmem_ack), .trap(trap), .dmem_req(dmem_req), .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en),
        .mem_wb_flush(mem_wb_flush), .mem_fault(mem_fault), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ex_re, ex_we, br, m_re, m_we, ack, trap;
    } stim_t;

    // ctrl = {dmem_req, pc_en, if_id en/flush, id_ex en/flush, ex_mem en/flush, mem_wb en/flush}
    typedef struct packed {
        logic [9:0]    ctrl;
        logic          fault;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int compared = 0, mismatched = 0;

    // Reference model state: cycles the current access has already waited,
    // pending fault pulse, stall-cycle tally, and whether the MEM stage was flushed.
    int age = 0;
    bit m_fault = 0;
    int m_cnt = 0;
    bit flushed = 0;

    task automatic step(input stim_t s);
        bit acc, req, to, lu, stall;
        logic [8:0] pat;
        exp_t x;
        @(posedge clk);
        #1;
        if (flushed) begin
            s.m_re = 1'b0;
            s.m_we = 1'b0;
        end
        rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_reg_file_rd = s.rd;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_data_re = s.ex_re; ex_reg_file_we = s.ex_we;
        ex_branch_taken = s.br; mem_data_re = s.m_re; mem_data_we = s.m_we;
        dmem_ack = s.ack; trap = s.trap;
        acc   = s.m_re | s.m_we;
        req   = !s.rst && (age > 0 || acc);
        to    = req && !s.ack && (age == TO - 1);
        lu    = s.ex_re && s.ex_we && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        stall = req && !s.ack && !to;
        if (s.rst)               pat = 9'b0_00_00_00_00;
        else if (s.trap || to)   pat = 9'b1_11_11_11_11;
        else if (stall)          pat = 9'b0_00_00_00_11;
        else if (s.br)           pat = 9'b1_11_11_10_10;
        else if (lu)             pat = 9'b0_00_11_10_10;
        else                     pat = 9'b1_10_10_10_10;
        x.ctrl  = {req, pat};
        x.fault = m_fault;
        x.cnt   = CW'(m_cnt);
        q.push_back(x);
        if (s.rst) begin
            age = 0; m_fault = 0; m_cnt = 0; flushed = 0;
        end else begin
            m_fault = to;
            if (!pat[8]) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            flushed = s.trap || to;
            age = (s.trap || to || !req || s.ack) ? 0 : age + 1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if ({dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush} !== e.ctrl) begin
                mismatched++;
                $display("FAIL ctrl t=%0t got %b expected %b", $time,
                         {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                          ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush}, e.ctrl);
            end
            compared++;
            if (mem_fault !== e.fault) begin
                mismatched++;
                $display("FAIL mem_fault t=%0t got %b expected %b", $time, mem_fault, e.fault);
            end
            compared++;
            if (stall_count !== e.cnt) begin
                mismatched++;
                $display("FAIL stall_count t=%0t got %0d expected %0d", $time, stall_count, e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    stim_t s;

    initial begin
        s = '0; s.rst = 1; step(s); step(s);
        // load-use on rs1, then a quiet cycle
        s = '0; s.ex_re = 1; s.ex_we = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; step(s);
        s = '0; step(s);
        // same pattern targeting x0: no stall
        s = '0; s.ex_re = 1; s.ex_we = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; step(s);
        // store acked on the fourth request cycle
        s = '0; s.m_we = 1; repeat (3) step(s);
        s.ack = 1; step(s);
        s = '0; step(s);
        // load never acked: timeout
        s = '0; s.m_re = 1; repeat (4) step(s);
        s = '0; repeat (2) step(s);
        // branch beats load-use
        s = '0; s.br = 1; s.ex_re = 1; s.ex_we = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; step(s);
        // branch held during memory stall, flushes in the ack cycle
        s = '0; s.m_re = 1; s.br = 1; repeat (2) step(s);
        s.ack = 1; step(s);
        s = '0; step(s);
        // trap while waiting
        s = '0; s.m_we = 1; repeat (2) step(s);
        s.trap = 1; step(s);
        s = '0; step(s);
        // reset while waiting
        s = '0; s.m_re = 1; repeat (2) step(s);
        s.rst = 1; step(s);
        s = '0; step(s);
        repeat (3000) begin
            s.rst   = ($urandom_range(99) == 0);
            s.rs1   = 5'($urandom_range(3));
            s.rs2   = 5'($urandom_range(3));
            s.rd    = 5'($urandom_range(3));
            s.u1    = 1'($urandom_range(1));
            s.u2    = 1'($urandom_range(1));
            s.ex_re = 1'($urandom_range(1));
            s.ex_we = ($urandom_range(3) != 0);
            s.br    = ($urandom_range(4) == 0);
            s.m_re  = ($urandom_range(4) == 0);
            s.m_we  = ($urandom_range(4) == 0);
            s.ack   = ($urandom_range(2) == 0);
            s.trap  = ($urandom_range(19) == 0);
            step(s);
        end
        @(negedge clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
